io_display_out: RTL

Memory-mapped output peripheral for the processor board, the write-side counterpart of the switch/button input registers in the register file. It snoops the register file writeback port, captures writes to two designated output registers, and drives the 16 board LEDs plus an 8-digit multiplexed, active-low seven-segment display. Display updates are double-buffered and committed only at frame boundaries so the digits never tear mid-scan.

---
 rtl/io_display_out.sv | 128 ++++++++++++
 1 files changed

// File: rtl/io_display_out.sv
// Memory-mapped LED and 8-digit seven-segment output peripheral.
// Snoops register-file writebacks; display value is double-buffered and committed per frame.
module io_display_out #(
  parameter int unsigned LED_REG      = 24,
  parameter int unsigned DISP_REG     = 25,
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        ctrl_writeEnable,
  input  logic [4:0]  ctrl_writeReg,
  input  logic [31:0] data_writeReg,
  output logic [15:0] LED,
  output logic [6:0]  SEG,
  output logic [7:0]  AN
);

  localparam int unsigned CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int unsigned IDX_W = 3;

  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [15:0]      led_q;
  logic [31:0]      disp_active_q;
  logic [31:0]      disp_pending_q;
  logic             pending_q;

  logic             led_wr_c;
  logic             disp_wr_c;
  logic             slot_end_c;
  logic             commit_c;
  logic             blank_c;
  logic [3:0]       nibble_c;
  logic [7:0]       an_d_c;
  logic [6:0]       seg_d_c;

  // Active-low {g,f,e,d,c,b,a} hex font
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Write decode, scan timing and next output values
  always_comb begin
    led_wr_c   = 1'b0;
    disp_wr_c  = 1'b0;
    slot_end_c = 1'b0;
    commit_c   = 1'b0;
    blank_c    = 1'b0;
    nibble_c   = 4'h0;
    an_d_c     = 8'hFF;
    seg_d_c    = 7'h7F;

    // Index 0 is the hardwired zero register and never maps to a peripheral
    if (ctrl_writeEnable && (ctrl_writeReg != 5'd0)) begin
      led_wr_c  = (ctrl_writeReg == 5'(LED_REG));
      disp_wr_c = (ctrl_writeReg == 5'(DISP_REG));
    end

    slot_end_c = (cnt_q == CNT_W'(DIGIT_CYCLES - 1));
    commit_c   = slot_end_c && (idx_q == 3'd7) && pending_q;
    blank_c    = (cnt_q < CNT_W'(BLANK_CYCLES));
    nibble_c   = disp_active_q[{idx_q, 2'b00} +: 4];

    if (!blank_c) begin
      an_d_c  = ~(8'h01 << idx_q);
      seg_d_c = hex7(nibble_c);
    end
  end

  // Scan counters, capture registers and registered outputs
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      led_q          <= '0;
      disp_active_q  <= '0;
      disp_pending_q <= '0;
      pending_q      <= 1'b0;
      AN             <= 8'hFF;
      SEG            <= 7'h7F;
    end else begin
      if (slot_end_c) begin
        cnt_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (led_wr_c) led_q <= data_writeReg[15:0];

      // A write on the commit edge refills the buffer and keeps it pending
      if (disp_wr_c) begin
        disp_pending_q <= data_writeReg;
        pending_q      <= 1'b1;
      end else if (commit_c) begin
        pending_q <= 1'b0;
      end

      if (commit_c) disp_active_q <= disp_pending_q;

      AN  <= an_d_c;
      SEG <= seg_d_c;
    end
  end

  assign LED = led_q;

endmodule
